// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed 8-digit seven-segment scan engine. Each digit owns one slot
// of SLOT_CYCLES clocks; digits are scanned 0..7. The digit-enable vector and
// the packed segment patterns are snapshotted once per frame (and once right
// after reset), so the source can update at any time without tearing a scan.
// Every digit occupies its slot even when it is disabled, which keeps the
// brightness of the enabled digits uniform.
//
// Optional build macro: SEVSEG_GHOST_GUARD_EN
//   When defined, the anodes are held off for the first GUARD_CYCLES of every
//   slot so the cathodes can settle before a digit lights (anti-ghosting).
//   When undefined, GUARD_CYCLES has no effect.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   AN_In        in   8   digit enable, active-high, bit k = digit k
//   C_In         in  56   segment patterns, active-high, digit k = C_In[7k+6:7k]
//                         (bit0 = segment a ... bit6 = segment g)
//   AN_Out       out  8   anode drive, active-low, at most one bit low
//   C_Out        out  7   cathode drive, active-low, {g..a}
//   frame_start  out  1   one-cycle pulse when the digit-0 slot begins with a
//                         fresh snapshot
//
// All outputs are registered and lag the internal slot/digit state by one clock.
// There is no handshake: inputs are sampled only on snapshot cycles.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN_In,
    input  logic [55:0] C_In,
    output logic [7:0]  AN_Out,
    output logic [6:0]  C_Out,
    output logic        frame_start
);

    localparam int             CW        = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0]  SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]  GUARD_LIM = CW'(GUARD_CYCLES);
`ifdef SEVSEG_GHOST_GUARD_EN
    localparam logic           GUARD_EN  = 1'b1;
`else
    localparam logic           GUARD_EN  = 1'b0;
`endif

    // Scan state
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          primed_q, primed_d;

    // Per-frame snapshot of the inputs
    logic [7:0]    shadow_an_q, shadow_an_d;
    logic [55:0]   shadow_c_q, shadow_c_d;

    // Registered outputs
    logic [7:0]    an_q, an_d;
    logic [6:0]    c_q, c_d;
    logic          fs_q, fs_d;

    logic          slot_end;
    logic          load;
    logic          guard_active;
    logic [6:0]    digit_seg;

    always_comb begin
        slot_end = (slot_cnt_q == SLOT_LAST);

        // Snapshot on the 7->0 digit transition, and on the very first cycle
        // after reset so the display never scans stale all-zero shadows for a
        // whole frame.
        load = !primed_q || (slot_end && (idx_q == 3'd7));

        slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 3'd1 : idx_q;
        primed_d    = 1'b1;
        shadow_an_d = load ? AN_In : shadow_an_q;
        shadow_c_d  = load ? C_In  : shadow_c_q;

        digit_seg = 7'h00;
        for (int k = 0; k < 8; k++) begin
            if (idx_q == 3'(k)) begin
                digit_seg = shadow_c_q[7*k +: 7];
            end
        end

        // Only the anodes are blanked during the guard window; the cathodes
        // switch immediately so they have settled by the time a digit lights.
        guard_active = GUARD_EN && (slot_cnt_q < GUARD_LIM);

        an_d = guard_active ? 8'hFF : ~((8'b1 << idx_q) & shadow_an_q);
        c_d  = ~digit_seg;
        fs_d = load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            idx_q       <= 3'd0;
            primed_q    <= 1'b0;
            shadow_an_q <= 8'h00;
            shadow_c_q  <= 56'h0;
            an_q        <= 8'hFF;
            c_q         <= 7'h7F;
            fs_q        <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            idx_q       <= idx_d;
            primed_q    <= primed_d;
            shadow_an_q <= shadow_an_d;
            shadow_c_q  <= shadow_c_d;
            an_q        <= an_d;
            c_q         <= c_d;
            fs_q        <= fs_d;
        end
    end

    assign AN_Out      = an_q;
    assign C_Out       = c_q;
    assign frame_start = fs_q;

endmodule
